// File: rtl/num_ascii_pkg.sv
// Shared definitions for the ASCII<->binary codec pair: controller state
// encoding and the ASCII constants both directions use.
package num_ascii_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONVERT = 3'd1,
        SIGN    = 3'd2,
        DIGIT   = 3'd3,
        TERM    = 3'd4
    } state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_CR    = 8'h0D;

endpackage

// File: rtl/num_2_ascii_encoder_dabble.sv
// Iterative shift-add-3 (double dabble) binary to BCD engine: load captures the
// magnitude, each step performs one correction+shift, done flags the final step.
module bin2bcd_dabble #(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_W-1:0]     bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  done
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]   shift;
    logic [DATA_W-1:0]   shift_nxt;
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] bcd_nxt;
    logic [CNT_W-1:0]    count;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        {bcd_nxt, shift_nxt} = {adj, shift} << 1;
    end

    // done is asserted during the step that produces the final BCD value
    assign done = step && (count == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd   <= '0;
            shift <= '0;
            count <= '0;
        end else if (load) begin
            bcd   <= '0;
            shift <= bin;
            count <= '0;
        end else if (step) begin
            bcd   <= bcd_nxt;
            shift <= shift_nxt;
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/num_2_ascii_encoder.sv
// Signed binary to ASCII serialiser: double-dabble conversion, optional '-',
// digits MSD first, optional terminator. Macro NUM2ASCII_LZS_EN suppresses leading zeros.
module num_2_ascii_encoder
    import num_ascii_pkg::*;
#(
    parameter int         DATA_W    = 16,
    parameter int         DIGITS    = 5,
    parameter bit         SEND_TERM = 1'b1,
    parameter logic [7:0] TERM_CHAR = ASCII_CR
) (
    input  logic              Encoder_Clk,
    input  logic              Encoder_Clr,
    input  logic              Start,
    input  logic [DATA_W-1:0] Bin_In,
    input  logic              Out_Ready,
    output logic [7:0]        ASCII_Out,
    output logic              Out_Valid,
    output logic              Busy,
    output logic              Done
);
    localparam int               IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(DIGITS - 1);

    state_t              state, state_nxt;
    logic                neg;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    eff_idx;
    logic [DATA_W-1:0]   mag;
    logic [4*DIGITS-1:0] bcd;
    logic [3:0]          digit;
    logic                load, step, conv_done, xfer_last;

    // Two's-complement negate; the most negative value maps onto its unsigned magnitude
    assign mag  = Bin_In[DATA_W-1] ? (~Bin_In + 1'b1) : Bin_In;
    assign load = (state == IDLE) && Start;
    assign step = (state == CONVERT);

    bin2bcd_dabble #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_dabble (
        .clk   (Encoder_Clk),
        .rst_n (Encoder_Clr),
        .load  (load),
        .step  (step),
        .bin   (mag),
        .bcd   (bcd),
        .done  (conv_done)
    );

`ifdef NUM2ASCII_LZS_EN
    logic [IDX_W-1:0] lead_idx;

    always_comb begin
        lead_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0)
                lead_idx = IDX_W'(i);
        end
    end

    // Clamping to the leading non-zero digit skips zeros without spending cycles
    assign eff_idx = (idx > lead_idx) ? lead_idx : idx;
`else
    assign eff_idx = idx;
`endif

    always_comb begin
        digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (eff_idx == IDX_W'(i))
                digit = bcd[4*i +: 4];
        end
    end

    always_comb begin
        state_nxt = state;
        xfer_last = 1'b0;
        ASCII_Out = 8'h00;
        case (state)
            IDLE: begin
                if (Start)
                    state_nxt = CONVERT;
            end
            CONVERT: begin
                if (conv_done)
                    state_nxt = neg ? SIGN : DIGIT;
            end
            SIGN: begin
                ASCII_Out = ASCII_MINUS;
                if (Out_Ready)
                    state_nxt = DIGIT;
            end
            DIGIT: begin
                ASCII_Out = ASCII_ZERO + {4'd0, digit};
                if (Out_Ready && (eff_idx == '0)) begin
                    if (SEND_TERM) begin
                        state_nxt = TERM;
                    end else begin
                        state_nxt = IDLE;
                        xfer_last = 1'b1;
                    end
                end
            end
            TERM: begin
                ASCII_Out = TERM_CHAR;
                if (Out_Ready) begin
                    state_nxt = IDLE;
                    xfer_last = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign Out_Valid = (state == SIGN) || (state == DIGIT) || (state == TERM);
    assign Busy      = (state != IDLE);

    always_ff @(posedge Encoder_Clk or negedge Encoder_Clr) begin
        if (!Encoder_Clr)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge Encoder_Clk or negedge Encoder_Clr) begin
        if (!Encoder_Clr) begin
            neg  <= 1'b0;
            idx  <= '0;
            Done <= 1'b0;
        end else begin
            Done <= xfer_last;
            if (load) begin
                neg <= Bin_In[DATA_W-1];
                idx <= TOP_IDX;
            end else if ((state == DIGIT) && Out_Ready && (eff_idx != '0)) begin
                idx <= eff_idx - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_num_2_ascii_encoder.sv
// Self-checking bench for num_2_ascii_encoder: fixed vector table, handshake and
// reset corner sequences, and randomized values against a decimal reference model.
module tb_num_2_ascii_encoder;

    localparam int DATA_W    = 16;
    localparam int DIGITS    = 5;
    localparam bit SEND_TERM = 1'b1;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [DATA_W-1:0] bin_in;
    logic              out_ready;
    logic [7:0]        ascii_out;
    logic              out_valid;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         stall_seen;

    typedef struct {
        logic [15:0] val;
        logic [63:0] exp;   // {byte count, up to 7 bytes left aligned}
    } vec_t;

    num_2_ascii_encoder #(
        .DATA_W    (DATA_W),
        .DIGITS    (DIGITS),
        .SEND_TERM (SEND_TERM),
        .TERM_CHAR (8'h0D)
    ) dut (
        .Encoder_Clk (clk),
        .Encoder_Clr (rst_n),
        .Start       (start),
        .Bin_In      (bin_in),
        .Out_Ready   (out_ready),
        .ASCII_Out   (ascii_out),
        .Out_Valid   (out_valid),
        .Busy        (busy),
        .Done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic [7:0] q[$]);
        logic [55:0] d = '0;
        for (int i = 0; i < 7; i++)
            d = {d[47:0], (i < q.size()) ? q[i] : 8'h00};
        return {8'(q.size()), d};
    endfunction

    // Reference: decimal digits by division, then apply the framing rules
    task automatic build_exp(input logic [15:0] v);
        int s, m, first;
        int d[DIGITS];
        s = int'($signed(v));
        m = (s < 0) ? -s : s;
        for (int i = 0; i < DIGITS; i++) begin
            d[i] = m % 10;
            m    = m / 10;
        end
        first = DIGITS - 1;
`ifdef NUM2ASCII_LZS_EN
        first = 0;
        for (int i = 0; i < DIGITS; i++)
            if (d[i] != 0) first = i;
`endif
        exp_q.delete();
        if (s < 0) exp_q.push_back(8'h2D);
        for (int i = first; i >= 0; i--) exp_q.push_back(8'(8'h30 + d[i]));
        if (SEND_TERM) exp_q.push_back(8'h0D);
    endtask

    // Called at a negedge; returns at the negedge where Done is seen.
    // mode 0: always ready, 1: random ready, 2: 3-cycle stall on the 2nd byte.
    task automatic run(input string name, input logic [15:0] v, input int mode, input bit inject);
        int cyc, first_v, last_x;
        bit busy_ok, stable_ok, done_seen, prev_stall;
        logic [7:0] prev_b;
        got_q.delete();
        stall_seen = 0;
        start  = 1'b1;
        bin_in = v;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        bin_in = DATA_W'($urandom);
        cyc = 1; first_v = -1; last_x = -1;
        busy_ok = 1'b1; stable_ok = 1'b1; done_seen = 1'b0; prev_stall = 1'b0; prev_b = 8'h00;
        while (cyc < 200 && !done_seen) begin
            if (done) begin
                done_seen = 1'b1;
                check({name, "_done_timing"}, 64'(cyc - last_x), 64'd1);
                check({name, "_busy_at_done"}, 64'(busy), 64'd0);
            end else begin
                if (!busy) busy_ok = 1'b0;
                if (prev_stall && (!out_valid || ascii_out !== prev_b)) stable_ok = 1'b0;
                if (out_valid && first_v < 0) first_v = cyc;
                start = inject && (cyc == 4 || cyc == 18);
                if (start) bin_in = 16'd9999;
                case (mode)
                    0: out_ready = 1'b1;
                    1: out_ready = ($urandom_range(0, 9) < 7);
                    default: begin
                        if (out_valid && got_q.size() == 1 && stall_seen < 3) begin
                            out_ready = 1'b0;
                            stall_seen++;
                        end else begin
                            out_ready = 1'b1;
                        end
                    end
                endcase
                if (out_valid && out_ready) begin
                    got_q.push_back(ascii_out);
                    last_x = cyc;
                end
                prev_stall = out_valid && !out_ready;
                prev_b     = ascii_out;
                @(negedge clk);
                cyc++;
            end
        end
        if (!done_seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout got=no Done within %0d cycles expected=Done", name, cyc);
        end
        start = 1'b0;
        check({name, "_latency"}, 64'(first_v), 64'(DATA_W + 1));
        check({name, "_busy"}, 64'(busy_ok), 64'd1);
        check({name, "_hold"}, 64'(stable_ok), 64'd1);
    endtask

    task automatic reset_mid(input string name, input int wait_cyc);
        start  = 1'b1;
        bin_in = 16'd1234;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b0;
        repeat (wait_cyc) @(negedge clk);
        check({name, "_busy_before"}, 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check({name, "_outputs"}, {53'd0, ascii_out, out_valid, busy, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t tbl[5];

    initial begin
`ifdef NUM2ASCII_LZS_EN
        tbl[0] = '{16'd1234, 64'h05313233340D0000};
        tbl[1] = '{16'hFFFF, 64'h032D310D00000000};
        tbl[2] = '{16'h8000, 64'h072D33323736380D};
        tbl[3] = '{16'h0000, 64'h02300D0000000000};
        tbl[4] = '{16'h7FFF, 64'h0633323736370D00};
`else
        tbl[0] = '{16'd1234, 64'h0630313233340D00};
        tbl[1] = '{16'hFFFF, 64'h072D30303030310D};
        tbl[2] = '{16'h8000, 64'h072D33323736380D};
        tbl[3] = '{16'h0000, 64'h0630303030300D00};
        tbl[4] = '{16'h7FFF, 64'h0633323736370D00};
`endif
        rst_n     = 1'b0;
        start     = 1'b0;
        bin_in    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ascii", 64'(ascii_out), 64'd0);
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_busy",  64'(busy), 64'd0);
        check("reset_done",  64'(done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run($sformatf("tbl%0d", i), tbl[i].val, 0, 1'b0);
            check($sformatf("tbl%0d_seq", i), pack(got_q), tbl[i].exp);
        end

        run("stall", 16'd1234, 2, 1'b0);
        build_exp(16'd1234);
        check("stall_seq", pack(got_q), pack(exp_q));
        check("stall_cycles", 64'(stall_seen), 64'd3);

        run("busy_start", 16'd1234, 0, 1'b1);
        check("busy_start_seq", pack(got_q), pack(exp_q));

        reset_mid("rst_conv", 5);
        run("after_rst", 16'd4321, 0, 1'b0);
        build_exp(16'd4321);
        check("after_rst_seq", pack(got_q), pack(exp_q));

        reset_mid("rst_out", 19);
        run("after_rst2", 16'hFB2E, 1, 1'b0);
        build_exp(16'hFB2E);
        check("after_rst2_seq", pack(got_q), pack(exp_q));

        for (int i = 0; i < 40; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            if (i % 8 == 0) v = 16'($urandom_range(0, 9));
            if (i % 8 == 1) v = 16'hFFFF - 16'($urandom_range(0, 9));
            run($sformatf("rnd%0d", i), v, 1, 1'b0);
            build_exp(v);
            check($sformatf("rnd%0d_seq_%0h", i, v), pack(got_q), pack(exp_q));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
